// File: rtl/ifu_if.sv
// Fetch-stage bus: redirect/exception controls in, fetched instruction and status out.
interface ifu_if;
  logic        en;
  logic        br_taken_D;
  logic [31:0] br_target_D;
  logic        jump_D;
  logic [31:0] jump_target_D;
  logic        Int_entry;
  logic        Iferet_M;
  logic [31:0] EPC;
  logic [31:0] IR_F;
  logic [31:0] PC4_F;
  logic [31:0] PC_F;
  logic        AdEL_F;
  logic        BD_F;
  logic [31:0] fetch_cnt;

  modport master (
    output en, br_taken_D, br_target_D, jump_D, jump_target_D,
           Int_entry, Iferet_M, EPC,
    input  IR_F, PC4_F, PC_F, AdEL_F, BD_F, fetch_cnt
  );

  modport slave (
    input  en, br_taken_D, br_target_D, jump_D, jump_target_D,
           Int_entry, Iferet_M, EPC,
    output IR_F, PC4_F, PC_F, AdEL_F, BD_F, fetch_cnt
  );
endinterface

// File: rtl/ifu.sv
// Instruction-fetch stage: PC register, next-PC selection, instruction ROM read
// and fetch address-error detection. The ROM image is bound at elaboration.
module ifu #(
  parameter logic [31:0]                PC_RESET   = 32'h0000_3000,
  parameter logic [31:0]                EXC_VECTOR = 32'h0000_4180,
  parameter int unsigned                IM_WORDS   = 4096,
  parameter logic [IM_WORDS-1:0][31:0]  IM_IMAGE   = '0
) (
  input  logic  clk,
  input  logic  reset,
  ifu_if.slave  bus
);

  localparam int unsigned IDX_W   = $clog2(IM_WORDS);
  localparam logic [31:0] PC_LAST = PC_RESET + 32'(4 * IM_WORDS) - 32'd4;

  logic [31:0]      pc;
  logic [31:0]      cnt;
  logic             bd;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [31:0]      seq_pc;
  logic             adel;
  logic [IDX_W-1:0] idx;

  // Jump has priority over a simultaneous taken branch.
  always_comb begin
    redirect    = bus.jump_D | bus.br_taken_D;
    redirect_pc = bus.jump_D ? bus.jump_target_D : bus.br_target_D;
    seq_pc      = pc + 32'd4;
  end

  // Exception entry and eret override a stall; fetch count only moves on accepted cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc  <= PC_RESET;
      bd  <= 1'b0;
      cnt <= '0;
    end else if (bus.Int_entry) begin
      pc <= EXC_VECTOR;
      bd <= 1'b0;
    end else if (bus.Iferet_M) begin
      pc <= bus.EPC;
      bd <= 1'b0;
    end else if (bus.en) begin
      pc  <= redirect ? redirect_pc : seq_pc;
      bd  <= redirect;
      cnt <= cnt + 32'd1;
    end
  end

  // Misaligned or out-of-image fetches never touch the ROM and fetch a nop.
  always_comb begin
    adel = (pc[1:0] != 2'b00) | (pc < PC_RESET) | (pc > PC_LAST);
    idx  = IDX_W'((pc - PC_RESET) >> 2);
  end

  assign bus.PC_F      = pc;
  assign bus.PC4_F     = seq_pc;
  assign bus.AdEL_F    = adel;
  assign bus.IR_F      = adel ? 32'd0 : IM_IMAGE[idx];
  assign bus.BD_F      = bd;
  assign bus.fetch_cnt = cnt;

endmodule

// File: tb/tb_ifu.sv
// Scoreboard bench for ifu: directed vectors push expected fetch state, a monitor compares.
module tb_ifu;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        bd;
    logic [31:0] cnt;
    logic        adel;
  } exp_t;

  function automatic logic [31:0] rom_word(input int unsigned i);
    return {16'hAD00 ^ 16'(i * 7), 16'(i)};
  endfunction

  function automatic logic [4095:0][31:0] make_image();
    logic [4095:0][31:0] img;
    img = '0;
    for (int hi = 0; hi < 64; hi++) begin
      for (int lo = 0; lo < 64; lo++) begin
        img[hi * 64 + lo] = rom_word(32'(hi * 64 + lo));
      end
    end
    return img;
  endfunction

  logic clk = 1'b0;
  logic reset;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  ifu_if bus ();

  ifu #(.IM_IMAGE(make_image())) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h", name, field, act, exp);
    end
  endtask

  task automatic vec(input string name, input logic rst, input logic en,
                     input logic j, input logic [31:0] jt,
                     input logic br, input logic [31:0] bt,
                     input logic intr, input logic eret, input logic [31:0] epc,
                     input logic [31:0] e_pc, input logic e_bd,
                     input logic [31:0] e_cnt, input logic e_adel);
    exp_t e;
    @(posedge clk);
    #2;
    reset             = rst;
    bus.en            = en;
    bus.jump_D        = j;
    bus.jump_target_D = jt;
    bus.br_taken_D    = br;
    bus.br_target_D   = bt;
    bus.Int_entry     = intr;
    bus.Iferet_M      = eret;
    bus.EPC           = epc;
    e.name = name; e.pc = e_pc; e.bd = e_bd; e.cnt = e_cnt; e.adel = e_adel;
    sb.push_back(e);
  endtask

  // Monitor: state after each edge is checked against the oldest expectation.
  initial begin
    exp_t        e;
    logic [31:0] exp_ir;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e      = sb.pop_front();
        exp_ir = e.adel ? 32'd0 : rom_word((e.pc - 32'h0000_3000) >> 2);
        chk(e.name, "PC_F",      bus.PC_F,            e.pc);
        chk(e.name, "PC4_F",     bus.PC4_F,           e.pc + 32'd4);
        chk(e.name, "IR_F",      bus.IR_F,            exp_ir);
        chk(e.name, "AdEL_F",    32'(bus.AdEL_F),     32'(e.adel));
        chk(e.name, "BD_F",      32'(bus.BD_F),       32'(e.bd));
        chk(e.name, "fetch_cnt", bus.fetch_cnt,       e.cnt);
      end
    end
  end

  initial begin
    int wait_cycles;
    reset = 1'b1;
    bus.en = 1'b0; bus.jump_D = 1'b0; bus.jump_target_D = '0;
    bus.br_taken_D = 1'b0; bus.br_target_D = '0;
    bus.Int_entry = 1'b0; bus.Iferet_M = 1'b0; bus.EPC = '0;

    //   name        rst en j  jt            br bt            int eret epc           pc            bd cnt adel
    vec("reset",     1, 0, 0, 32'h0,       0, 32'h0,       0, 0, 32'h0,        32'h0000_3000, 0, 0,  0);
    vec("seq1",      0, 1, 0, 32'h0,       0, 32'h0,       0, 0, 32'h0,        32'h0000_3004, 0, 1,  0);
    vec("seq2",      0, 1, 0, 32'h0,       0, 32'h0,       0, 0, 32'h0,        32'h0000_3008, 0, 2,  0);
    vec("branch",    0, 1, 0, 32'h0,       1, 32'h3020,    0, 0, 32'h0,        32'h0000_3020, 1, 3,  0);
    vec("after_br",  0, 1, 0, 32'h0,       0, 32'h0,       0, 0, 32'h0,        32'h0000_3024, 0, 4,  0);
    vec("jmp_wins",  0, 1, 1, 32'h3100,    1, 32'h3040,    0, 0, 32'h0,        32'h0000_3100, 1, 5,  0);
    vec("stall1",    0, 0, 1, 32'h3200,    0, 32'h0,       0, 0, 32'h0,        32'h0000_3100, 1, 5,  0);
    vec("stall2",    0, 0, 1, 32'h3200,    0, 32'h0,       0, 0, 32'h0,        32'h0000_3100, 1, 5,  0);
    vec("stall3",    0, 0, 1, 32'h3200,    0, 32'h0,       0, 0, 32'h0,        32'h0000_3100, 1, 5,  0);
    vec("jmp_rel",   0, 1, 1, 32'h3180,    0, 32'h0,       0, 0, 32'h0,        32'h0000_3180, 1, 6,  0);
    vec("int_stall", 0, 0, 0, 32'h0,       0, 32'h0,       1, 0, 32'h0,        32'h0000_4180, 0, 6,  0);
    vec("eret",      0, 0, 0, 32'h0,       0, 32'h0,       0, 1, 32'h3010,     32'h0000_3010, 0, 6,  0);
    vec("seq3",      0, 1, 0, 32'h0,       0, 32'h0,       0, 0, 32'h0,        32'h0000_3014, 0, 7,  0);
    vec("int_eret",  0, 1, 0, 32'h0,       0, 32'h0,       1, 1, 32'h3500,     32'h0000_4180, 0, 7,  0);
    vec("seq4",      0, 1, 0, 32'h0,       0, 32'h0,       0, 0, 32'h0,        32'h0000_4184, 0, 8,  0);
    vec("misalign",  0, 1, 1, 32'h3002,    0, 32'h0,       0, 0, 32'h0,        32'h0000_3002, 1, 9,  1);
    vec("misalign2", 0, 1, 0, 32'h0,       0, 32'h0,       0, 0, 32'h0,        32'h0000_3006, 0, 10, 1);
    vec("past_end",  0, 1, 0, 32'h0,       1, 32'h7000,    0, 0, 32'h0,        32'h0000_7000, 1, 11, 1);
    vec("rst_redir", 1, 1, 1, 32'h3100,    0, 32'h0,       0, 0, 32'h0,        32'h0000_3000, 0, 0,  0);
    vec("last_word", 0, 1, 1, 32'h6FFC,    0, 32'h0,       0, 0, 32'h0,        32'h0000_6FFC, 1, 1,  0);
    vec("one_past",  0, 1, 0, 32'h0,       0, 32'h0,       0, 0, 32'h0,        32'h0000_7000, 0, 2,  1);
    vec("below",     0, 1, 0, 32'h0,       0, 32'h0,       0, 1, 32'h2FFC,     32'h0000_2FFC, 0, 2,  1);
    vec("int_low",   0, 0, 0, 32'h0,       0, 32'h0,       1, 0, 32'h0,        32'h0000_4180, 0, 2,  0);
    vec("stall_br",  0, 0, 0, 32'h0,       1, 32'h3300,    0, 0, 32'h0,        32'h0000_4180, 0, 2,  0);
    vec("rst_stall", 1, 0, 0, 32'h0,       0, 32'h0,       0, 0, 32'h0,        32'h0000_3000, 0, 0,  0);
    vec("eret_top",  0, 0, 0, 32'h0,       0, 32'h0,       0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 1);
    vec("pc_wrap",   0, 1, 0, 32'h0,       0, 32'h0,       0, 0, 32'h0,        32'h0000_0000, 0, 1,  1);
    vec("final_rst", 1, 0, 0, 32'h0,       0, 32'h0,       0, 0, 32'h0,        32'h0000_3000, 0, 0,  0);

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
